imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 20, instruction word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 8, instruction-memory address width.
REQ-003 SHALL have parameter MEM_SIZE, default 256, instruction-memory depth in words.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  single-cycle pulse that begins a load frame.
REQ-007 in_data  input  8  byte of the incoming load stream.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 mem_we  output  1  instruction-memory write strobe.
REQ-011 mem_addr  output  ADDRESS_WIDTH  write address.
REQ-012 mem_wdata  output  DATA_WIDTH  write data.
REQ-013 busy  output  1  frame in progress.
REQ-014 done  output  1  frame completed; CPU may leave reset.
REQ-015 error  output  1  checksum mismatch; constant 0 when the checksum option is compiled out.

Function
REQ-016 A byte SHALL transfer only on a clock edge with in_valid=1 and in_ready=1.
REQ-017 States SHALL be IDLE, COUNT, B0, B1, B2, WRITE, CHECK, DONE; in_ready=1 only in COUNT, B0, B1, B2, CHECK.
REQ-018 IDLE/DONE + start=1 -> COUNT; busy=1 in COUNT through CHECK; done and error cleared on that transition.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 COUNT: accepted byte stores N-1 (frame length 1..256 words) -> B0; word index reset to 0.
REQ-021 Word bytes arrive LSB first: B0 -> wdata[7:0], B1 -> wdata[15:8], B2 -> wdata[19:16] from bits [3:0]; bits [7:4] ignored.
REQ-022 After the B2 transfer -> WRITE; in WRITE mem_we=1 for exactly one cycle with mem_addr=index and mem_wdata=assembled word (write one cycle after the third byte).
REQ-023 WRITE -> B0 with index+1 if index < N-1; otherwise -> CHECK (option on) or DONE (option off).
REQ-024 Index SHALL never exceed MEM_SIZE-1; N-1 >= MEM_SIZE SHALL be clamped to MEM_SIZE-1.
REQ-025 DONE: done=1, busy=0, in_ready=0, mem_we=0; held until start or rst.
REQ-026 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-027 in_valid low for any number of cycles in a byte state SHALL stall without losing state.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE, index 0, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0.
REQ-029 rst asserted mid-frame SHALL abort the frame; no further mem_we until a new start.

Configuration
REQ-030 Macro IMEM_LOADER_CHECKSUM_EN defined: an 8-bit running XOR covers the count byte and all payload bytes; CHECK accepts one checksum byte, error=1 if it differs from the running XOR, then -> DONE (done=1 regardless of error).
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN undefined: no CHECK state logic, WRITE of the last word -> DONE, error tied to 0.

Verification
REQ-032 start, bytes 00,34,12,05 (valid every cycle) -> one mem_we, addr 0x00, wdata 0x51234; done=1 the cycle after the write.
REQ-033 N=3 words with in_valid toggled 1/0 each cycle -> writes to addr 0,1,2 in order with correct data; in_ready=0 during every WRITE cycle.
REQ-034 Count byte FF, 768 payload bytes -> 256 writes, last addr 0xFF, done=1; no write past 0xFF.
REQ-035 rst pulsed after B1 of word 2 -> all outputs at reset values; new start with N=1 writes addr 0 correctly.
REQ-036 Checksum option on, frame 00,34,12,05 + checksum 23 -> error=0; checksum 24 -> error=1; done=1 in both.
REQ-037 start pulsed during B1 -> ignored; frame completes with the original count and data.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Streams a program image byte by byte into an instruction memory while the
// CPU is held in reset. A frame is: one count byte (N-1, so 1..256 words),
// then three bytes per word, least significant first. The third byte only
// contributes its low nibble, giving a 20-bit instruction word. Each
// assembled word is written one cycle after its last byte arrives.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to append a checksum byte
// to the frame. It must equal the XOR of the count byte and all payload
// bytes; a mismatch raises error. Without the macro, error is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      single-cycle pulse that begins a frame (ignored while busy)
//   in_data    byte of the incoming load stream
//   in_valid   in_data is valid
//   in_ready   loader accepts in_data this cycle
//   mem_we     instruction-memory write strobe
//   mem_addr   write address (holds its value between writes)
//   mem_wdata  write data (holds its value between writes)
//   busy       frame in progress
//   done       frame completed; CPU may leave reset
//   error      checksum mismatch (0 when the checksum option is absent)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int unsigned LAST_IDX = MEM_SIZE - 1;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        B0,
        B1,
        B2,
        WRITE,
        CHECK,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic                     xfer;
    logic [ADDRESS_WIDTH-1:0] index;
    logic [ADDRESS_WIDTH-1:0] last_idx;
    logic [7:0]               byte0;
    logic [7:0]               byte1;

    assign xfer = in_valid & in_ready;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = COUNT;
            COUNT:      if (xfer)  state_next = B0;
            B0:         if (xfer)  state_next = B1;
            B1:         if (xfer)  state_next = B2;
            B2:         if (xfer)  state_next = WRITE;
            WRITE: begin
                if (index < last_idx) begin
                    state_next = B0;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK:      if (xfer)  state_next = DONE;
`endif
            default:    state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            COUNT, B0, B1, B2: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    // The write port registers are loaded on the third byte so that they are
    // already valid during WRITE and simply hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index     <= '0;
            last_idx  <= '0;
            byte0     <= '0;
            byte1     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                COUNT: begin
                    if (xfer) begin
                        index <= '0;
                        // Frames longer than the memory are truncated.
                        if (32'(in_data) > LAST_IDX) begin
                            last_idx <= ADDRESS_WIDTH'(LAST_IDX);
                        end else begin
                            last_idx <= ADDRESS_WIDTH'(in_data);
                        end
                    end
                end
                B0: if (xfer) byte0 <= in_data;
                B1: if (xfer) byte1 <= in_data;
                B2: begin
                    if (xfer) begin
                        mem_addr  <= index;
                        mem_wdata <= DATA_WIDTH'({in_data[3:0], byte1, byte0});
                    end
                end
                WRITE: if (index < last_idx) index <= index + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum  <= '0;
            error <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) error <= 1'b0;
                COUNT:      if (xfer)  csum <= in_data;
                B0, B1, B2: if (xfer)  csum <= csum ^ in_data;
                CHECK:      if (xfer)  error <= (in_data != csum);
                default: ;
            endcase
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. A per-cycle vector table covers the
// basic single-word frame and a start pulse arriving mid-frame; hand-written
// sequences cover stalled input, a full 256-word frame, an aborting reset
// and (with IMEM_LOADER_CHECKSUM_EN) the checksum result.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [19:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(
        .DATA_WIDTH   (20),
        .ADDRESS_WIDTH(8),
        .MEM_SIZE     (256)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        rdy;
        logic        we;
        logic [7:0]  addr;
        logic [19:0] wd;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    typedef logic [7:0] bq_t[$];

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_v(input logic s, input logic v, input logic [7:0] d,
                         input logic r, input logic we, input logic [7:0] a,
                         input logic [19:0] wd, input logic b, input logic dn,
                         input logic er);
        vec_t t;
        t = '{s, v, d, r, we, a, wd, b, dn, er};
        vecs.push_back(t);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  0);
        chk({tag, "_mem_we"},    32'(mem_we),    0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_done"},      32'(done),      0);
        chk({tag, "_error"},     32'(error),     0);
    endtask

    // Offer one byte until the loader takes it (bounded).
    task automatic feed(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        chk("feed_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Run a whole frame from a byte list; expected writes derive from the list.
    task automatic run_frame(input string tag, input bq_t b, input bit toggle,
                             input bit add_csum, input logic exp_err);
        int        n_words;
        int        idx;
        int        wcnt;
        int        budget;
        bit        ph;
        logic [7:0] x;
        logic [19:0] exp_wd;

        n_words = int'(b[0]) + 1;
        if (n_words > 256) n_words = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (add_csum) begin
            x = '0;
            foreach (b[i]) x = x ^ b[i];
            b.push_back(x);
        end
`endif
        budget = 2 * b.size() + 2 * n_words + 20;
        idx  = 0;
        wcnt = 0;
        ph   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (mem_we) begin
                chk({tag, "_write_in_range"}, 32'(wcnt < n_words), 1);
                if (wcnt < n_words) begin
                    exp_wd = {b[3*wcnt+3][3:0], b[3*wcnt+2], b[3*wcnt+1]};
                    chk($sformatf("%s_addr[%0d]", tag, wcnt), 32'(mem_addr), 32'(wcnt));
                    chk($sformatf("%s_wdata[%0d]", tag, wcnt), 32'(mem_wdata), 32'(exp_wd));
                end
                chk({tag, "_ready_in_write"}, 32'(in_ready), 0);
                wcnt++;
            end
            if (done) break;
            in_valid = (toggle ? ph : 1'b1) && (idx < b.size());
            in_data  = (idx < b.size()) ? b[idx] : 8'h00;
            ph = ~ph;
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({tag, "_done"},        32'(done),  1);
        chk({tag, "_busy_done"},   32'(busy),  0);
        chk({tag, "_write_count"}, 32'(wcnt),  32'(n_words));
        chk({tag, "_error"},       32'(error), 32'(exp_err));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk({tag, "_no_write_after_done"}, 32'(mem_we), 0);
            chk({tag, "_done_held"},           32'(done),   1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t fr;

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---- vector table: start s v data | rdy we addr wdata busy done err
        // single word 00,34,12,05
        add_v(1, 0, 8'h00, 0, 0, 8'h00, 20'h00000, 0, 0, 0); // IDLE
        add_v(0, 1, 8'h00, 1, 0, 8'h00, 20'h00000, 1, 0, 0); // COUNT
        add_v(0, 1, 8'h34, 1, 0, 8'h00, 20'h00000, 1, 0, 0); // B0
        add_v(0, 1, 8'h12, 1, 0, 8'h00, 20'h00000, 1, 0, 0); // B1
        add_v(0, 1, 8'h05, 1, 0, 8'h00, 20'h00000, 1, 0, 0); // B2
        add_v(0, 0, 8'h00, 0, 1, 8'h00, 20'h51234, 1, 0, 0); // WRITE
`ifdef IMEM_LOADER_CHECKSUM_EN
        add_v(0, 1, 8'h23, 1, 0, 8'h00, 20'h51234, 1, 0, 0); // CHECK
`endif
        add_v(0, 1, 8'hFF, 0, 0, 8'h00, 20'h51234, 0, 1, 0); // DONE, ignores data
        // start during B1 is ignored; upper nibble of the third byte dropped
        add_v(1, 0, 8'h00, 0, 0, 8'h00, 20'h51234, 0, 1, 0); // DONE + start
        add_v(0, 1, 8'h00, 1, 0, 8'h00, 20'h51234, 1, 0, 0); // COUNT
        add_v(0, 1, 8'hAA, 1, 0, 8'h00, 20'h51234, 1, 0, 0); // B0
        add_v(1, 1, 8'hBB, 1, 0, 8'h00, 20'h51234, 1, 0, 0); // B1 + start
        add_v(0, 1, 8'hFC, 1, 0, 8'h00, 20'h51234, 1, 0, 0); // B2
        add_v(0, 0, 8'h00, 0, 1, 8'h00, 20'hCBBAA, 1, 0, 0); // WRITE
`ifdef IMEM_LOADER_CHECKSUM_EN
        add_v(0, 1, 8'hED, 1, 0, 8'h00, 20'hCBBAA, 1, 0, 0); // CHECK
`endif
        add_v(0, 0, 8'h00, 0, 0, 8'h00, 20'hCBBAA, 0, 1, 0); // DONE
        add_v(0, 0, 8'h00, 0, 0, 8'h00, 20'hCBBAA, 0, 1, 0); // DONE held

        for (int i = 0; i < vecs.size(); i++) begin
            start    = vecs[i].start;
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            #1;
            chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].rdy));
            chk($sformatf("v%0d_mem_we", i),    32'(mem_we),    32'(vecs[i].we));
            chk($sformatf("v%0d_mem_addr", i),  32'(mem_addr),  32'(vecs[i].addr));
            chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].wd));
            chk($sformatf("v%0d_busy", i),      32'(busy),      32'(vecs[i].busy));
            chk($sformatf("v%0d_done", i),      32'(done),      32'(vecs[i].done));
            chk($sformatf("v%0d_error", i),     32'(error),     32'(vecs[i].err));
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;

        // ---- three words with in_valid toggling every cycle
        fr = '{8'h02, 8'h01, 8'h02, 8'h03, 8'hA4, 8'hB5, 8'h76, 8'hFF, 8'hEE, 8'h1D};
        run_frame("stall3", fr, 1'b1, 1'b1, 1'b0);

        // ---- full-depth frame: 256 words
        fr = '{8'hFF};
        for (int i = 0; i < 768; i++) fr.push_back(8'($urandom_range(0, 255)));
        run_frame("full256", fr, 1'b0, 1'b1, 1'b0);
        chk("full256_last_addr", 32'(mem_addr), 32'hFF);

        // ---- reset in the middle of word 2 (after its second byte)
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed(8'h02);
        feed(8'h11);
        feed(8'h22);
        feed(8'h03);
        feed(8'h44);
        feed(8'h55);
        chk("abort_busy_before", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_write", 32'(mem_we), 0);
            chk("abort_idle",     32'(busy),   0);
        end
        fr = '{8'h00, 8'h78, 8'h56, 8'h0F};
        run_frame("after_abort", fr, 1'b0, 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // ---- explicit checksum bytes: 23 matches, 24 does not
        fr = '{8'h00, 8'h34, 8'h12, 8'h05, 8'h23};
        run_frame("csum_ok", fr, 1'b0, 1'b0, 1'b0);
        fr = '{8'h00, 8'h34, 8'h12, 8'h05, 8'h24};
        run_frame("csum_bad", fr, 1'b0, 1'b0, 1'b1);
        // error clears on the next start
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("csum_error_cleared", 32'(error), 0);
        fr = '{8'h00, 8'h01, 8'h02, 8'h03};
        run_frame("csum_after", fr, 1'b0, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
